// File: rtl/traffic_generator.sv
// ---------------------------------------------------------------------------
// traffic_generator
// Packet source for one mesh node. It injects NumPackets packets into the
// router Local input port. Each request waits InjectionGap idle cycles after
// the previous grant, and no request starts while the router buffer is full.
// The destination is either the fixed DestID or a pseudo-random node taken
// from a 4-bit LFSR. A random destination that equals the node's own ID is
// replaced, so the generator never sends a packet to itself.
//
// Packet layout: [31:22] zero, [21:16] destination, [15:6] PacketID,
//                [5:0] ModuleID
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset       : asynchronous active-low reset
//   PacketOut   : packet presented to the router Local input
//   ReqDnStr    : request to the router to accept PacketOut
//   GntDnStr    : grant from the router (packet accepted)
//   DnStrFull   : router Local input buffer full
//   Done        : all packets have been sent
//   PacketsSent : number of granted packets
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_GAP | counting idle cycles; issues the next request when allowed
// REQUEST  | ReqDnStr high, PacketOut held until the router grants
// DONE     | all packets sent; idle until reset
// ---------------------------------------------------------------------------
module traffic_generator #(
   parameter logic [5:0] ModuleID     = 6'b000_000,
   parameter int         dataWidth    = 32,
   parameter int         dim          = 4,
   parameter int         NumPackets   = 16,
   parameter int         InjectionGap = 4,
   parameter int         TrafficMode  = 0,
   parameter logic [5:0] DestID       = 6'b001_001,
   parameter logic [3:0] LfsrSeed     = 4'b1001
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [dataWidth-1:0] PacketOut,
   output logic                 ReqDnStr,
   input  logic                 GntDnStr,
   input  logic                 DnStrFull,
   output logic                 Done,
   output logic [15:0]          PacketsSent
);

   // One coordinate field of a node ID is wide enough for dim rows plus a
   // spare bit. For dim=4 this gives the 3-bit x/y fields of the packet.
   localparam int CoordW = $clog2(dim) + 1;
   localparam int IdW    = 2 * CoordW;
   localparam int FieldW = IdW + 10 + 6;

   localparam logic [1:0]  WAIT_GAP = 2'd0;
   localparam logic [1:0]  REQUEST  = 2'd1;
   localparam logic [1:0]  DONE     = 2'd2;

   localparam logic [15:0] NumPkt   = 16'(NumPackets);
   localparam logic [7:0]  GapLimit = 8'(InjectionGap);

   logic [1:0]        state;
   logic [7:0]        gapCnt;
   logic [9:0]        packetId;
   logic [3:0]        lfsr;
   logic [3:0]        lfsrNext;
   logic [3:0]        nodeAlt;
   logic [IdW-1:0]    rndDest;
   logic [IdW-1:0]    nextDest;
   logic [FieldW-1:0] packetFields;

   // x^4 + x^3 + 1 Fibonacci LFSR. With a nonzero seed it never reaches 0.
   assign lfsrNext = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

   // The random node n maps to x = n[1:0] and y = n[3:2]. If that node is
   // our own ID, the neighbouring node n^1 is used instead.
   always_comb begin
      nodeAlt = lfsr ^ 4'b0001;
      rndDest = {1'b0, lfsr[1:0], 1'b0, lfsr[3:2]};
      if (rndDest == ModuleID) begin
         rndDest = {1'b0, nodeAlt[1:0], 1'b0, nodeAlt[3:2]};
      end
      if (TrafficMode == 1) begin
         nextDest = rndDest;
      end else begin
         nextDest = DestID;
      end
      packetFields = {nextDest, packetId, ModuleID};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PacketOut   <= '0;
         ReqDnStr    <= 1'b0;
         Done        <= 1'b0;
         PacketsSent <= '0;
         packetId    <= '0;
         gapCnt      <= '0;
         lfsr        <= LfsrSeed;
         state       <= WAIT_GAP;
      end else begin
         case (state)
            WAIT_GAP: begin
               if (PacketsSent == NumPkt) begin
                  Done  <= 1'b1;
                  state <= DONE;
               end else if ((gapCnt >= GapLimit) && !DnStrFull) begin
                  PacketOut <= {{(dataWidth - FieldW){1'b0}}, packetFields};
                  ReqDnStr  <= 1'b1;
                  state     <= REQUEST;
               end else if (gapCnt != 8'hFF) begin
                  gapCnt <= gapCnt + 8'd1;
               end
            end
            REQUEST: begin
               // Once a request is raised it stays up, even if the buffer
               // reports full again, until the router grants it.
               if (GntDnStr) begin
                  ReqDnStr    <= 1'b0;
                  packetId    <= packetId + 10'd1;
                  PacketsSent <= PacketsSent + 16'd1;
                  gapCnt      <= '0;
                  lfsr        <= lfsrNext;
                  state       <= WAIT_GAP;
               end
            end
            DONE: begin
               ReqDnStr <= 1'b0;
               Done     <= 1'b1;
            end
            default: begin
               state <= WAIT_GAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_generator.sv
module tb_traffic_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared  = 0;
   int nMismatch  = 0;

   // ---------------- DUT A: fixed destination, gap 2, 3 packets ----------
   logic        rstA     = 1'b0;
   logic        fullA    = 1'b0;
   logic        gntA     = 1'b0;
   logic        autoGntA = 1'b0;
   logic        reqPrevA = 1'b0;
   logic [31:0] pktA;
   logic        reqA;
   logic        doneA;
   logic [15:0] sentA;

   traffic_generator #(
      .ModuleID(6'b000_000), .dataWidth(32), .dim(4), .NumPackets(3),
      .InjectionGap(2), .TrafficMode(0), .DestID(6'b001_001), .LfsrSeed(4'b1001)
   ) dutA (
      .clk(clk), .reset(rstA), .PacketOut(pktA), .ReqDnStr(reqA),
      .GntDnStr(gntA), .DnStrFull(fullA), .Done(doneA), .PacketsSent(sentA)
   );

   // ---------------- DUTs B/C/D share one reset and a constant grant ------
   logic        rstX  = 1'b0;
   logic        gntHi = 1'b1;
   logic        fullLo = 1'b0;

   logic [31:0] pktB, pktC, pktD;
   logic        reqB, reqC, reqD;
   logic        doneB, doneC, doneD;
   logic [15:0] sentB, sentC, sentD;

   traffic_generator #(
      .ModuleID(6'b000_000), .NumPackets(1030), .InjectionGap(0),
      .TrafficMode(0), .DestID(6'b001_001)
   ) dutB (
      .clk(clk), .reset(rstX), .PacketOut(pktB), .ReqDnStr(reqB),
      .GntDnStr(gntHi), .DnStrFull(fullLo), .Done(doneB), .PacketsSent(sentB)
   );

   traffic_generator #(
      .ModuleID(6'b000_000), .NumPackets(15), .InjectionGap(1),
      .TrafficMode(1), .LfsrSeed(4'b1001)
   ) dutC (
      .clk(clk), .reset(rstX), .PacketOut(pktC), .ReqDnStr(reqC),
      .GntDnStr(gntHi), .DnStrFull(fullLo), .Done(doneC), .PacketsSent(sentC)
   );

   traffic_generator #(
      .ModuleID(6'b001_010), .NumPackets(16), .InjectionGap(1),
      .TrafficMode(1), .LfsrSeed(4'b1001)
   ) dutD (
      .clk(clk), .reset(rstX), .PacketOut(pktD), .ReqDnStr(reqD),
      .GntDnStr(gntHi), .DnStrFull(fullLo), .Done(doneD), .PacketsSent(sentD)
   );

   logic [31:0] qA[$];
   logic [31:0] qB[$];
   logic [31:0] qC[$];
   logic [31:0] qD[$];

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatch++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] buildPkt(input logic [5:0] d, input logic [9:0] id,
                                            input logic [5:0] m);
      return {10'b0, d, id, m};
   endfunction

   function automatic logic [5:0] mapNode(input logic [3:0] n);
      return {1'b0, n[1:0], 1'b0, n[3:2]};
   endfunction

   function automatic logic [5:0] randDest(input logic [3:0] n, input logic [5:0] own);
      logic [5:0] d;
      d = mapNode(n);
      if (d == own) d = mapNode(n ^ 4'b0001);
      return d;
   endfunction

   task automatic pushA(input int n);
      qA.delete();
      for (int i = 0; i < n; i++) qA.push_back(buildPkt(6'b001_001, 10'(i), 6'b000_000));
   endtask

   // Grant one cycle after the request becomes visible.
   always @(posedge clk) begin
      #1;
      gntA     = autoGntA && reqA && reqPrevA;
      reqPrevA = reqA;
   end

   // Scoreboard monitors: a granted cycle is the DUT producing a packet.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rstA && reqA && gntA) begin
         e = (qA.size() > 0) ? qA.pop_front() : 32'hDEAD_BEEF;
         checkVal("pktA", pktA, e);
      end
   end

   logic altErrB = 1'b0;
   logic sawReqB = 1'b0;
   logic prevReqB = 1'b0;

   always @(negedge clk) begin
      logic [31:0] e;
      if (rstX && !doneB) begin
         if (sawReqB && (reqB == prevReqB)) altErrB = 1'b1;
         if (reqB) sawReqB = 1'b1;
         prevReqB = reqB;
      end
      if (rstX && reqB && gntHi) begin
         e = (qB.size() > 0) ? qB.pop_front() : 32'hDEAD_BEEF;
         checkVal("pktB", pktB, e);
      end
      if (rstX && reqC && gntHi) begin
         e = (qC.size() > 0) ? qC.pop_front() : 32'hDEAD_BEEF;
         checkVal("pktC", pktC, e);
         checkVal("selfC", 64'(pktC[21:16] != 6'b000_000), 64'd1);
      end
      if (rstX && reqD && gntHi) begin
         e = (qD.size() > 0) ? qD.pop_front() : 32'hDEAD_BEEF;
         checkVal("pktD", pktD, e);
         checkVal("selfD", 64'(pktD[21:16] != 6'b001_010), 64'd1);
      end
   end

   initial begin
      logic [2:0]  reqHist;
      logic        reqSeen;
      logic        unstable;
      logic [3:0]  n;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      checkVal("rstReq",  reqA,  0);
      checkVal("rstDone", doneA, 0);
      checkVal("rstSent", sentA, 0);
      checkVal("rstPkt",  pktA,  0);

      // ---- basic sequence, first-request latency gap+1 ----
      pushA(3);
      rstA = 1'b1;
      reqHist = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         reqHist[i] = reqA;
      end
      checkVal("firstReqLat", reqHist, 3'b100);
      autoGntA = 1'b1;
      for (int i = 0; i < 200 && !doneA; i++) @(negedge clk);
      checkVal("doneA", doneA, 1);
      checkVal("sentA", sentA, 3);
      checkVal("sbA_left", qA.size(), 0);
      repeat (5) @(negedge clk);
      checkVal("doneHold", doneA, 1);
      checkVal("doneNoReq", reqA, 0);

      // ---- buffer full after reset blocks requests ----
      autoGntA = 1'b0;
      @(posedge clk);
      #1 rstA = 1'b0;
      pushA(3);
      fullA = 1'b1;
      @(posedge clk);
      #1 rstA = 1'b1;
      reqSeen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 reqSeen = reqSeen | reqA;
      end
      checkVal("fullNoReq", reqSeen, 0);
      fullA = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkVal("reqAfterFull", reqA, 1);

      // ---- grant withheld, full toggling: request held stable ----
      unstable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 fullA = ~fullA;
         @(negedge clk);
         if (reqA !== 1'b1 || pktA !== qA[0]) unstable = 1'b1;
      end
      checkVal("holdStable", unstable, 0);
      checkVal("holdSent", sentA, 0);
      fullA    = 1'b0;
      autoGntA = 1'b1;
      for (int i = 0; i < 200 && !doneA; i++) @(negedge clk);
      checkVal("doneA2", doneA, 1);
      checkVal("sentA2", sentA, 3);
      checkVal("sbA_left2", qA.size(), 0);

      // ---- reset in the middle of a request ----
      autoGntA = 1'b0;
      @(posedge clk);
      #1 rstA = 1'b0;
      pushA(3);
      @(posedge clk);
      #1 rstA = 1'b1;
      for (int i = 0; i < 10 && !reqA; i++) @(negedge clk);
      checkVal("reqBeforeRst", reqA, 1);
      #2 rstA = 1'b0;
      #1;
      checkVal("rstMidReq",  reqA,  0);
      checkVal("rstMidPkt",  pktA,  0);
      checkVal("rstMidSent", sentA, 0);
      pushA(3);
      @(posedge clk);
      #1 rstA = 1'b1;
      @(negedge clk);
      autoGntA = 1'b1;
      for (int i = 0; i < 200 && !doneA; i++) @(negedge clk);
      checkVal("doneA3", doneA, 1);
      checkVal("sbA_left3", qA.size(), 0);

      // ---- wrap run and random destinations ----
      for (int i = 0; i < 1030; i++) qB.push_back(buildPkt(6'b001_001, 10'(i), 6'b000_000));
      n = 4'b1001;
      for (int i = 0; i < 15; i++) begin
         qC.push_back(buildPkt(randDest(n, 6'b000_000), 10'(i), 6'b000_000));
         n = {n[2:0], n[3] ^ n[2]};
      end
      n = 4'b1001;
      for (int i = 0; i < 16; i++) begin
         qD.push_back(buildPkt(randDest(n, 6'b001_010), 10'(i), 6'b001_010));
         n = {n[2:0], n[3] ^ n[2]};
      end
      @(posedge clk);
      #1 rstX = 1'b1;
      for (int i = 0; i < 5000 && !(doneB && doneC && doneD); i++) @(negedge clk);
      checkVal("doneB", doneB, 1);
      checkVal("sentB", sentB, 1030);
      checkVal("sbB_left", qB.size(), 0);
      checkVal("altB", altErrB, 0);
      checkVal("doneC", doneC, 1);
      checkVal("sentC", sentC, 15);
      checkVal("sbC_left", qC.size(), 0);
      checkVal("doneD", doneD, 1);
      checkVal("sentD", sentD, 16);
      checkVal("sbD_left", qD.size(), 0);
      repeat (5) @(negedge clk);
      checkVal("doneHoldB", {doneB, reqB}, 2'b10);
      checkVal("sentHoldB", sentB, 1030);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/traffic_generator.md
TRAFFIC_GENERATOR -- requirements
Module: traffic_generator

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ModuleID, 6'b000_000, own node ID {x[2:0],y[2:0]}; placed in SenderID field.
- dataWidth, 32, packet bus width.
- dim, 4, mesh dimension; packet fields are sized for dim=4.
- NumPackets, 16, total packets to inject; range 1..65535.
- InjectionGap, 4, idle cycles between grant and next request; range 0..255.
- TrafficMode, 0, 0 = fixed destination DestID, 1 = LFSR pseudo-random destination.
- DestID, 6'b001_001, destination used when TrafficMode=0.
- LfsrSeed, 4'b1001, LFSR reset value; must be nonzero.
REQ-002 Ports, one per line: name, direction, width, meaning (clock and reset first):
- clk, in, 1, single clock; all state updates on posedge.
- reset, in, 1, asynchronous active-low reset.
- PacketOut, out, dataWidth, packet to the router Local input port.
- ReqDnStr, out, 1, request to the router to accept PacketOut.
- GntDnStr, in, 1, grant from the router; packet accepted.
- DnStrFull, in, 1, router Local input buffer full.
- Done, out, 1, all NumPackets packets sent.
- PacketsSent, out, 16, count of granted packets.

Function
REQ-003 Packet format: [31:22]=0, [21:16]=destination ID, [15:6]=PacketID (10 bits), [5:0]=ModuleID.
REQ-004 States: WAIT_GAP, REQUEST, DONE; all outputs are registered.
REQ-005 WAIT_GAP, evaluated in this priority order:
- if PacketsSent==NumPackets, go to DONE;
- else if gapCnt>=InjectionGap and DnStrFull==0, load PacketOut, set ReqDnStr=1, go to REQUEST;
- else increment gapCnt, saturating at 255.
REQ-006 With DnStrFull=1 in WAIT_GAP, no request is issued; gapCnt continues counting.
REQ-007 REQUEST: ReqDnStr and PacketOut are held stable until a cycle with GntDnStr==1.
REQ-008 DnStrFull rising while in REQUEST does not withdraw the request.
REQ-009 On a GntDnStr==1 cycle in REQUEST, the next edge performs all of:
- ReqDnStr<=0;
- PacketID<=PacketID+1, wrapping 1023->0;
- PacketsSent<=PacketsSent+1;
- gapCnt<=0;
- LFSR advances one step;
- state<=WAIT_GAP.
REQ-010 With InjectionGap=0 and no back-pressure, ReqDnStr is high for the grant cycle, low for exactly one cycle, then high again.
REQ-011 GntDnStr outside REQUEST is ignored; no counters change.
REQ-012 DONE: ReqDnStr=0 and Done=1; the state holds until reset.
REQ-013 LFSR: 4-bit Fibonacci, polynomial x^4+x^3+1, next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
REQ-014 TrafficMode=1 destination: node n=lfsr, destination ID={1'b0,n[1:0],1'b0,n[3:2]}.
REQ-015 If the mode-1 destination equals ModuleID, n^4'b0001 is used instead; the generator never self-addresses.
REQ-016 TrafficMode=0: destination field = DestID, LFSR unused.

Reset
REQ-017 On reset low, asynchronously and regardless of state:
- PacketOut=0, ReqDnStr=0, Done=0, PacketsSent=0;
- PacketID=0, gapCnt=0, lfsr=LfsrSeed, state=WAIT_GAP.
REQ-018 Reset in REQUEST drops ReqDnStr immediately; the pending packet is discarded, not re-sent with its old ID.
REQ-019 First request after reset release: InjectionGap+1 cycles later, given DnStrFull=0.

Verification
REQ-020 Setup ModuleID=000_000, DestID=001_001, InjectionGap=2, NumPackets=3, grant one cycle after request -> PacketOut=32'h0009_0000, 32'h0009_0040, 32'h0009_0080; then Done=1, PacketsSent=3.
REQ-021 DnStrFull held high 10 cycles after reset -> ReqDnStr stays 0; first request on the edge after DnStrFull falls.
REQ-022 GntDnStr withheld 20 cycles during REQUEST, DnStrFull toggling -> ReqDnStr and PacketOut stable throughout; PacketsSent unchanged.
REQ-023 NumPackets=1030, InjectionGap=0, grant always high -> PacketID wraps 1023->0; Done at PacketsSent=1030.
REQ-024 TrafficMode=1, seed 4'b1001, ModuleID=000_000 -> destinations follow the LFSR sequence with n=0 mapped to 1; no destination equals 000_000.
REQ-025 Reset asserted mid-REQUEST -> ReqDnStr=0 with no clock edge; after release the first packet has PacketID=0.
